mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage load/store unit sitting directly upstream of the 4 KB word-addressed data memory (10-bit word index, combinational read, write on posedge). It accepts one EX/MEM request per cycle and drives the memory's word address, write data and write enable. Byte and halfword stores are done by read-modify-write, which stalls the pipeline one cycle. Load results are lane-extracted, extended and registered into the MEM/WB register; misaligned accesses raise MIPS address-error exceptions.

Parameters:
DM_AW, 10, word-index width driven to data memory (byte address bits [DM_AW+1:2])
RD_W, 5, destination register tag width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle (valid & ready)
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=treated as word
req_unsigned  in  1  loads: zero-extend (LBU/LHU); ignored for stores
req_addr  in  32  byte address; bits above DM_AW+1 ignored
req_wdata  in  32  store data, right-aligned
req_rd  in  RD_W  load destination tag
dm_addr  out  DM_AW  word index to data memory
dm_din  out  32  write word to data memory
dm_we  out  1  data memory write enable
dm_dout  in  32  read word from data memory (combinational)
wb_valid  out  1  load result valid (MEM/WB register)
wb_data  out  32  extended load data
wb_rd  out  RD_W  load destination tag
exc_valid  out  1  address-error exception pulse
exc_code  out  5  4=AdEL, 5=AdES
exc_badvaddr  out  32  faulting byte address

Behaviour:
- Little-endian; byte lane = addr[1:0], half lane = addr[1].
- Alignment: half needs addr[0]=0, word needs addr[1:0]=0. Misaligned request is accepted and produces no memory write. Next cycle: exc_valid=1 with exc_code 4 (load) or 5 (store) and exc_badvaddr=req_addr; wb_valid=0.
- FSM states: IDLE, RMW_WR. req_ready=1 in IDLE, 0 in RMW_WR.
- IDLE, accepted aligned word store: dm_addr=req_addr word index, dm_din=req_wdata, dm_we=1 in the same cycle. Stay IDLE.
- IDLE, accepted aligned byte/half store: merge req_wdata low byte/half into dm_dout at the lane; latch merged word and word index; dm_we=0; go to RMW_WR.
- RMW_WR: dm_addr=latched index, dm_din=latched word, dm_we=1; go to IDLE. A request held on req_valid is not accepted and must be held by upstream.
- IDLE, accepted aligned load: extract the lane from dm_dout. Byte/half is sign- or zero-extended per req_unsigned; word is unchanged. At the next posedge: wb_data=result, wb_rd=req_rd, wb_valid=1.
- wb_valid and exc_valid are 1-cycle pulses and are 0 in any cycle with no qualifying accept. wb_data, wb_rd and exc_badvaddr hold their last value.
- Load latency: 1 cycle. Word store: 0 cycles. Sub-word store: 2 cycles, and a load accepted right after RMW_WR sees the new data.
- dm_we=0 whenever rst_n=0, when req_valid=0 in IDLE, and for misaligned requests.
- Reset, at posedge with rst_n=0: state=IDLE, wb_valid=0, wb_data=0, wb_rd=0, exc_valid=0, exc_code=0, exc_badvaddr=0. Reset during RMW_WR abandons the write and leaves memory unchanged.

Decomposition:
- Shared package/header: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), exception codes EXC_ADEL=4 and EXC_ADES=5, state encodings.
- One sub-module: mem_lane_align, purely combinational, containing the store merge (old word, data, size, lane -> new word) and the load extract/extend. The FSM and registers stay in the top module.

Test Plan:
- Word 0x10 preloaded 0x11223344. LW 0x40 rd=7 -> next cycle wb_valid=1, wb_data=0x11223344, wb_rd=7. SW 0x44 data 0xDEADBEEF -> dm_we=1 same cycle, req_ready stays 1, M[0x11]=0xDEADBEEF.
- M[0x10]=0x000080FF. LB 0x41 -> 0xFFFFFF80; LBU 0x41 -> 0x00000080; LH 0x40 -> 0xFFFF80FF; LHU 0x40 -> 0x000080FF; LB 0x40 -> 0xFFFFFFFF.
- M[0x10]=0x11223344. SB 0x42 data 0x000000AB -> req_ready=0 next cycle, dm_we=1 with dm_din=0x11AB3344, M[0x10]=0x11AB3344. SH 0x42 data 0xBEEF -> 0xBEEF3344.
- SB 0x42 immediately followed by held LW 0x40 -> LW accepted only after RMW_WR; wb_data=0x11AB3344.
- SH 0x41 -> exc_valid=1, exc_code=5, exc_badvaddr=0x41, dm_we never 1, memory unchanged. LW 0x42 -> exc_code=4, wb_valid=0.
- SB 0x43 with rst_n=0 in the RMW_WR cycle -> dm_we=0, M[0x10] unchanged, all outputs at reset values, req_ready=1 after reset.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size
// encodings, MIPS address-error exception codes, FSM states and small
// helpers for alignment and size classification.
package mem_access_unit_pkg;

  // Access size encodings carried on req_size (3 behaves like a word)
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // MIPS address-error exception codes
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Load/store unit control states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  // True when the access size is a byte or halfword
  function automatic logic isSubword(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

  // True when the low address bits violate the natural alignment of size
  function automatic logic isMisaligned(input logic [1:0] size,
                                        input logic [1:0] addrLow);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLow[0];
      default: bad = (addrLow != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus interfaces around the load/store unit: the pipeline side (EX/MEM
// request in, MEM/WB result and exception out) and the data-memory side.

// Pipeline-facing request/result/exception bundle
interface mem_access_unit_if #(
  parameter int RD_W = 5
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [RD_W-1:0] req_rd;
  logic            wb_valid;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            exc_valid;
  logic [4:0]      exc_code;
  logic [31:0]     exc_badvaddr;

  // Pipeline view: issues requests, consumes results
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  req_ready, wb_valid, wb_data, wb_rd, exc_valid, exc_code, exc_badvaddr
  );

  // Load/store unit view: serves requests, produces results
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output req_ready, wb_valid, wb_data, wb_rd, exc_valid, exc_code, exc_badvaddr
  );
endinterface

// Data-memory port: word index, write word/enable, combinational read word
interface mem_dm_if #(
  parameter int DM_AW = 10
);
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_din;
  logic             dm_we;
  logic [31:0]      dm_dout;

  // Load/store unit view: drives the memory
  modport master (
    output dm_addr, dm_din, dm_we,
    input  dm_dout
  );

  // Memory view
  modport slave (
    input  dm_addr, dm_din, dm_we,
    output dm_dout
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane logic for the load/store unit. The store half merges
// a right-aligned byte/half into the old memory word at the addressed lane;
// the load half pulls the addressed lane out of the read word and sign- or
// zero-extends it. Little-endian: byte lane = addr[1:0], half lane = addr[1].
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] oldWord_i,
  input  logic [31:0] storeData_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        loadUnsigned_i,
  output logic [31:0] mergedWord_o,
  output logic [31:0] loadData_o
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic        signBit;

  // Store merge: replace only the addressed lane of the old word
  always_comb begin
    mergedWord_o = oldWord_i;
    case (size_i)
      SZ_BYTE: begin
        case (lane_i)
          2'd0:    mergedWord_o[7:0]   = storeData_i[7:0];
          2'd1:    mergedWord_o[15:8]  = storeData_i[7:0];
          2'd2:    mergedWord_o[23:16] = storeData_i[7:0];
          default: mergedWord_o[31:24] = storeData_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane_i[1]) begin
          mergedWord_o[31:16] = storeData_i[15:0];
        end else begin
          mergedWord_o[15:0] = storeData_i[15:0];
        end
      end
      default: mergedWord_o = storeData_i;
    endcase
  end

  // Load extract: select the lane, then extend to 32 bits
  always_comb begin
    laneByte   = 8'h00;
    laneHalf   = 16'h0000;
    signBit    = 1'b0;
    loadData_o = oldWord_i;
    case (lane_i)
      2'd0:    laneByte = oldWord_i[7:0];
      2'd1:    laneByte = oldWord_i[15:8];
      2'd2:    laneByte = oldWord_i[23:16];
      default: laneByte = oldWord_i[31:24];
    endcase
    laneHalf = lane_i[1] ? oldWord_i[31:16] : oldWord_i[15:0];
    case (size_i)
      SZ_BYTE: begin
        signBit    = laneByte[7] & ~loadUnsigned_i;
        loadData_o = {{24{signBit}}, laneByte};
      end
      SZ_HALF: begin
        signBit    = laneHalf[15] & ~loadUnsigned_i;
        loadData_o = {{16{signBit}}, laneHalf};
      end
      default: loadData_o = oldWord_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-addressed data memory with
// combinational read and posedge write. Word stores write in the accept
// cycle; byte/half stores read the old word, merge, and write it back in a
// second cycle (RMW_WR) during which new requests are held off. Loads are
// extracted/extended and registered into the MEM/WB result. Misaligned
// accesses are swallowed and reported as AdEL/AdES one cycle later.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DM_AW = 10,
  parameter int RD_W  = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_access_unit_if.slave pipe,
  mem_dm_if.master         dm
);

  state_e state_q, state_d;

  logic [DM_AW-1:0] rmwAddr_q, rmwAddr_d;
  logic [31:0]      rmwWord_q, rmwWord_d;

  logic             wbValid_q, wbValid_d;
  logic [31:0]      wbData_q, wbData_d;
  logic [RD_W-1:0]  wbRd_q, wbRd_d;

  logic             excValid_q, excValid_d;
  logic [4:0]       excCode_q, excCode_d;
  logic [31:0]      excBad_q, excBad_d;

  logic [DM_AW-1:0] reqIndex;
  logic             misaligned;
  logic [31:0]      mergedWord;
  logic [31:0]      loadData;

  logic             reqReady;
  logic [DM_AW-1:0] dmAddr;
  logic [31:0]      dmDin;
  logic             dmWe;

  assign reqIndex   = pipe.req_addr[DM_AW+1:2];
  assign misaligned = isMisaligned(pipe.req_size, pipe.req_addr[1:0]);

  mem_lane_align u_lane_align (
    .oldWord_i      (dm.dm_dout),
    .storeData_i    (pipe.req_wdata),
    .size_i         (pipe.req_size),
    .lane_i         (pipe.req_addr[1:0]),
    .loadUnsigned_i (pipe.req_unsigned),
    .mergedWord_o   (mergedWord),
    .loadData_o     (loadData)
  );

  // Next-state, memory drive and result capture for the accept/RMW flow
  always_comb begin
    state_d    = state_q;
    rmwAddr_d  = rmwAddr_q;
    rmwWord_d  = rmwWord_q;
    wbValid_d  = 1'b0;
    wbData_d   = wbData_q;
    wbRd_d     = wbRd_q;
    excValid_d = 1'b0;
    excCode_d  = excCode_q;
    excBad_d   = excBad_q;
    reqReady   = 1'b0;
    dmAddr     = reqIndex;
    dmDin      = pipe.req_wdata;
    dmWe       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        reqReady = 1'b1;
        if (pipe.req_valid) begin
          if (misaligned) begin
            excValid_d = 1'b1;
            excCode_d  = pipe.req_we ? EXC_ADES : EXC_ADEL;
            excBad_d   = pipe.req_addr;
          end else if (pipe.req_we) begin
            if (isSubword(pipe.req_size)) begin
              rmwAddr_d = reqIndex;
              rmwWord_d = mergedWord;
              state_d   = ST_RMW_WR;
            end else begin
              dmWe = 1'b1;
            end
          end else begin
            wbValid_d = 1'b1;
            wbData_d  = loadData;
            wbRd_d    = pipe.req_rd;
          end
        end
      end
      ST_RMW_WR: begin
        dmAddr  = rmwAddr_q;
        dmDin   = rmwWord_q;
        dmWe    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, RMW latch and MEM/WB/exception registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rmwAddr_q  <= '0;
      rmwWord_q  <= '0;
      wbValid_q  <= 1'b0;
      wbData_q   <= '0;
      wbRd_q     <= '0;
      excValid_q <= 1'b0;
      excCode_q  <= '0;
      excBad_q   <= '0;
    end else begin
      state_q    <= state_d;
      rmwAddr_q  <= rmwAddr_d;
      rmwWord_q  <= rmwWord_d;
      wbValid_q  <= wbValid_d;
      wbData_q   <= wbData_d;
      wbRd_q     <= wbRd_d;
      excValid_q <= excValid_d;
      excCode_q  <= excCode_d;
      excBad_q   <= excBad_d;
    end
  end

  // Memory writes are suppressed outright while reset is asserted, which is
  // what abandons an in-flight RMW write-back
  assign dm.dm_addr = dmAddr;
  assign dm.dm_din  = dmDin;
  assign dm.dm_we   = dmWe & rst_n;

  assign pipe.req_ready    = reqReady;
  assign pipe.wb_valid     = wbValid_q;
  assign pipe.wb_data      = wbData_q;
  assign pipe.wb_rd        = wbRd_q;
  assign pipe.exc_valid    = excValid_q;
  assign pipe.exc_code     = excCode_q;
  assign pipe.exc_badvaddr = excBad_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a behavioural data memory, a reference
// model of the load/store rules, directed cases and a randomized stream.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int DM_AW = 10;
  localparam int RD_W  = 5;

  typedef struct {
    logic            we;
    logic [1:0]      size;
    logic            uns;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [RD_W-1:0] rd;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_access_unit_if #(.RD_W(RD_W))  pipe ();
  mem_dm_if          #(.DM_AW(DM_AW)) dm ();

  mem_access_unit #(.DM_AW(DM_AW), .RD_W(RD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pipe  (pipe),
    .dm    (dm)
  );

  always #5 clk = ~clk;

  // Behavioural data memory with a bench-side preload port
  logic [31:0]      mem [0:1023];
  logic             preWe = 1'b0;
  logic [DM_AW-1:0] preIdx = '0;
  logic [31:0]      preData = '0;

  assign dm.dm_dout = mem[dm.dm_addr];

  always @(posedge clk) begin
    if (dm.dm_we) mem[dm.dm_addr] <= dm.dm_din;
    else if (preWe) mem[preIdx] <= preData;
  end

  // Reference model state
  logic [31:0]      refMem [0:1023];
  req_t             q [$];
  bit               busy = 1'b0;
  logic [DM_AW-1:0] pendIdx = '0;
  logic [31:0]      pendWord = '0;
  logic [31:0]      expWbData = '0;
  logic [RD_W-1:0]  expWbRd = '0;
  logic [31:0]      expBad = '0;
  bit               gaps = 1'b0;
  int               errors = 0;
  int               checks = 0;

  function automatic logic refMis(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return addr[0];
    if (size >= 2'd2) return addr[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic uns);
    longint v;
    if (size == 2'd0) begin
      v = (longint'(word) >> (8 * lane)) & 255;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = (longint'(word) >> (16 * lane[1])) & 65535;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(word);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] refMerge(input logic [31:0] old, input logic [31:0] data,
                                           input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] mask;
    int          sh;
    mask = (size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    sh   = (size == 2'd0) ? 8 * lane : 16 * lane[1];
    return (old & ~(mask << sh)) | ((data & mask) << sh);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushReq(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [RD_W-1:0] rd);
    req_t r;
    r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata; r.rd = rd;
    q.push_back(r);
  endtask

  task automatic preload(input logic [DM_AW-1:0] idx, input logic [31:0] data);
    @(negedge clk);
    pipe.req_valid = 1'b0;
    preWe = 1'b1; preIdx = idx; preData = data;
    @(posedge clk);
    #1;
    preWe = 1'b0;
    refMem[idx] = data;
  endtask

  // One clock cycle: present the head request (held while the unit is busy),
  // check the combinational memory drive, then the registered results
  task automatic applyStimulus();
    req_t r;
    bit   drive, accepted, wasBusy, mis, expWb, expExc;
    logic [4:0] expCode;
    @(negedge clk);
    drive = (q.size() > 0) && (busy || !gaps || ($urandom_range(3) != 0));
    if (drive) begin
      r = q[0];
      pipe.req_valid    = 1'b1;
      pipe.req_we       = r.we;
      pipe.req_size     = r.size;
      pipe.req_unsigned = r.uns;
      pipe.req_addr     = r.addr;
      pipe.req_wdata    = r.wdata;
      pipe.req_rd       = r.rd;
    end else begin
      pipe.req_valid = 1'b0;
    end
    #1;
    wasBusy  = busy;
    accepted = drive && !busy;
    mis      = accepted && refMis(r.size, r.addr);
    checkOutput("req_ready", pipe.req_ready, !busy);
    if (wasBusy) begin
      checkOutput("rmw_we", dm.dm_we, 1'b1);
      checkOutput("rmw_addr", dm.dm_addr, pendIdx);
      checkOutput("rmw_din", dm.dm_din, pendWord);
    end else if (accepted && !mis && r.we && r.size >= 2'd2) begin
      checkOutput("sw_we", dm.dm_we, 1'b1);
      checkOutput("sw_addr", dm.dm_addr, r.addr[DM_AW+1:2]);
      checkOutput("sw_din", dm.dm_din, r.wdata);
    end else begin
      checkOutput("dm_we_idle", dm.dm_we, 1'b0);
    end
    @(posedge clk);
    #1;
    expWb = 1'b0; expExc = 1'b0; expCode = 5'd0;
    if (wasBusy) begin
      refMem[pendIdx] = pendWord;
      busy = 1'b0;
    end else if (accepted) begin
      void'(q.pop_front());
      if (mis) begin
        expExc  = 1'b1;
        expCode = r.we ? 5'd5 : 5'd4;
        expBad  = r.addr;
      end else if (r.we && r.size >= 2'd2) begin
        refMem[r.addr[DM_AW+1:2]] = r.wdata;
      end else if (r.we) begin
        pendIdx  = r.addr[DM_AW+1:2];
        pendWord = refMerge(refMem[pendIdx], r.wdata, r.size, r.addr[1:0]);
        busy     = 1'b1;
      end else begin
        expWb     = 1'b1;
        expWbData = refLoad(refMem[r.addr[DM_AW+1:2]], r.size, r.addr[1:0], r.uns);
        expWbRd   = r.rd;
      end
    end
    checkOutput("wb_valid", pipe.wb_valid, expWb);
    checkOutput("wb_data", pipe.wb_data, expWbData);
    checkOutput("wb_rd", pipe.wb_rd, expWbRd);
    checkOutput("exc_valid", pipe.exc_valid, expExc);
    if (expExc) checkOutput("exc_code", pipe.exc_code, expCode);
    checkOutput("exc_badvaddr", pipe.exc_badvaddr, expBad);
  endtask

  // Cycle with rst_n low: no memory write, every output back at its reset value
  task automatic resetCycle();
    @(negedge clk);
    rst_n = 1'b0;
    pipe.req_valid = 1'b0;
    #1;
    checkOutput("rst_dm_we", dm.dm_we, 1'b0);
    @(posedge clk);
    #1;
    busy = 1'b0; q.delete();
    expWbData = '0; expWbRd = '0; expBad = '0;
    checkOutput("rst_ready", pipe.req_ready, 1'b1);
    checkOutput("rst_wb_valid", pipe.wb_valid, 1'b0);
    checkOutput("rst_wb_data", pipe.wb_data, 32'h0);
    checkOutput("rst_wb_rd", pipe.wb_rd, '0);
    checkOutput("rst_exc_valid", pipe.exc_valid, 1'b0);
    checkOutput("rst_exc_code", pipe.exc_code, 5'd0);
    checkOutput("rst_exc_bad", pipe.exc_badvaddr, 32'h0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((q.size() > 0 || busy) && budget < 4000) begin
      applyStimulus();
      budget++;
    end
    checkOutput("drain_timeout", q.size() + int'(busy), 0);
  endtask

  logic [31:0] lbAddr [5] = '{32'h41, 32'h41, 32'h40, 32'h40, 32'h40};
  logic [1:0]  lbSize [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
  logic        lbUns  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] lbExp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                              32'h0000_80FF, 32'hFFFF_FFFF};

  initial begin
    pipe.req_valid = 1'b0; pipe.req_we = 1'b0; pipe.req_size = 2'd0;
    pipe.req_unsigned = 1'b0; pipe.req_addr = '0; pipe.req_wdata = '0; pipe.req_rd = '0;

    resetCycle();
    resetCycle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 16; i < 24; i++) preload(DM_AW'(i), $urandom);

    // Word load and word store
    preload(10'h10, 32'h1122_3344);
    pushReq(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 5'd7);
    applyStimulus();
    checkOutput("lw_const", pipe.wb_data, 32'h1122_3344);
    checkOutput("lw_rd_const", pipe.wb_rd, 32'd7);
    pushReq(1'b1, SZ_WORD, 1'b0, 32'h44, 32'hDEAD_BEEF, 5'd0);
    applyStimulus();
    checkOutput("sw_mem_const", mem[10'h11], 32'hDEAD_BEEF);

    // Sub-word load extraction and extension
    preload(10'h10, 32'h0000_80FF);
    for (int i = 0; i < 5; i++) begin
      pushReq(1'b0, lbSize[i], lbUns[i], lbAddr[i], 32'h0, 5'(i + 1));
      applyStimulus();
      checkOutput("subload_const", pipe.wb_data, lbExp[i]);
    end

    // Sub-word stores through read-modify-write
    preload(10'h10, 32'h1122_3344);
    pushReq(1'b1, SZ_BYTE, 1'b0, 32'h42, 32'h0000_00AB, 5'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("sb_mem_const", mem[10'h10], 32'h11AB_3344);
    pushReq(1'b1, SZ_HALF, 1'b0, 32'h42, 32'h0000_BEEF, 5'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("sh_mem_const", mem[10'h10], 32'hBEEF_3344);

    // Load held behind the RMW write sees the merged word
    preload(10'h10, 32'h1122_3344);
    pushReq(1'b1, SZ_BYTE, 1'b0, 32'h42, 32'h0000_00AB, 5'd0);
    pushReq(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 5'd3);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("held_lw_const", pipe.wb_data, 32'h11AB_3344);

    // Misaligned store and load
    pushReq(1'b1, SZ_HALF, 1'b0, 32'h41, 32'h0000_1234, 5'd0);
    applyStimulus();
    checkOutput("ades_code", pipe.exc_code, 32'd5);
    checkOutput("ades_bad", pipe.exc_badvaddr, 32'h41);
    checkOutput("ades_mem", mem[10'h10], 32'h11AB_3344);
    pushReq(1'b0, SZ_WORD, 1'b0, 32'h42, 32'h0, 5'd9);
    applyStimulus();
    checkOutput("adel_code", pipe.exc_code, 32'd4);

    // Reset during the RMW write-back cycle abandons the write
    pushReq(1'b1, SZ_BYTE, 1'b0, 32'h43, 32'h0000_0055, 5'd0);
    applyStimulus();
    resetCycle();
    checkOutput("rst_rmw_mem", mem[10'h10], 32'h11AB_3344);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", pipe.req_ready, 1'b1);

    // Randomized request stream with idle gaps
    gaps = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pushReq(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
              32'h40 + 32'($urandom_range(31)) + (32'($urandom_range(7)) << 12),
              $urandom, RD_W'($urandom_range(31)));
    end
    drain();
    for (int i = 16; i < 24; i++) checkOutput("final_mem", mem[i], refMem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
